// File: rtl/receiver_hs.sv
// ---------------------------------------------------------------------------
// receiver_hs
//   Receive-side endpoint of a 4-phase req/ack bundled-data clock-domain
//   crossing. The asynchronous request is synchronised into clk_r. The
//   bundled data bus is captured once the synchronised request is seen. The
//   acknowledge goes back to the sender, and each captured byte is offered to
//   a local consumer over a valid/rd_en handshake with backpressure.
//
// Parameters
//   SYNC_STAGES : flops in the req_in synchroniser chain (2..4)
//   CNT_W       : width of the received-byte counter
//
// Ports
//   clk_r      in   receive-domain clock
//   reset_r    in   synchronous, active-high reset
//   req_in     in   asynchronous request; data valid while high
//   datain     in   8-bit bundled data, stable while req_in is high
//   ack_out    out  registered acknowledge to the sender
//   dataout    out  registered captured byte
//   valid      out  dataout holds an unread byte
//   rd_en      in   consumer takes dataout when valid is high
//   busy       out  FSM is outside IDLE
//   rx_count   out  bytes captured since reset (wraps silently)
//
// Optional feature (macro RECEIVER_HS_PARITY_EN)
//   parity_in  in   even-parity bit sent with datain
//   parity_err out  (^datain ^ parity_in) of the last capture; 1 = error
// ---------------------------------------------------------------------------
module receiver_hs #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_r,
    input  logic             reset_r,
    input  logic             req_in,
    input  logic [7:0]       datain,
    output logic             ack_out,
    output logic [7:0]       dataout,
    output logic             valid,
    input  logic             rd_en,
    output logic             busy,
`ifdef RECEIVER_HS_PARITY_EN
    input  logic             parity_in,
    output logic             parity_err,
`endif
    output logic [CNT_W-1:0] rx_count
);

    typedef enum logic [1:0] {
        StIdle,
        StAck,
        StWaitLow
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ack_q, ack_d;
    logic [7:0]             dataout_q, dataout_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic [CNT_W-1:0]       rx_count_q, rx_count_d;
    logic                   req_sync;
    logic                   capture;
`ifdef RECEIVER_HS_PARITY_EN
    logic                   parity_err_q, parity_err_d;
`endif

    // Stage 0 samples the raw asynchronous request; the last stage is safe to use.
    assign req_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], req_in};
        state_d    = state_q;
        ack_d      = ack_q;
        dataout_d  = dataout_q;
        valid_d    = valid_q;
        rx_count_d = rx_count_q;
        capture    = 1'b0;
`ifdef RECEIVER_HS_PARITY_EN
        parity_err_d = parity_err_q;
`endif

        case (state_q)
            StIdle: begin
                // Hold off the sender (no ack) while an unread byte is pending.
                if (req_sync && (!valid_q || rd_en)) begin
                    capture = 1'b1;
                    ack_d   = 1'b1;
                    state_d = StAck;
                end
            end
            StAck: begin
                ack_d   = 1'b1;
                state_d = StWaitLow;
            end
            StWaitLow: begin
                // Return to zero before another capture is allowed.
                if (!req_sync) begin
                    ack_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = StIdle;
            end
        endcase

        // A capture on the same edge as a read keeps valid high with the new byte.
        if (capture) begin
            dataout_d  = datain;
            valid_d    = 1'b1;
            rx_count_d = rx_count_q + CNT_W'(1);
`ifdef RECEIVER_HS_PARITY_EN
            parity_err_d = (^datain) ^ parity_in;
`endif
        end else if (valid_q && rd_en) begin
            valid_d = 1'b0;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_r) begin
        if (reset_r) begin
            state_q    <= StIdle;
            sync_q     <= '0;
            ack_q      <= 1'b0;
            dataout_q  <= 8'h00;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            rx_count_q <= '0;
`ifdef RECEIVER_HS_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            ack_q      <= ack_d;
            dataout_q  <= dataout_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            rx_count_q <= rx_count_d;
`ifdef RECEIVER_HS_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign ack_out  = ack_q;
    assign dataout  = dataout_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign rx_count = rx_count_q;
`ifdef RECEIVER_HS_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_receiver_hs.sv
// ---------------------------------------------------------------------------
// tb_receiver_hs
//   Directed bench for receiver_hs. The counter is built 4 bits wide so the
//   wrap from all-ones to zero is reached in a handful of transfers.
// ---------------------------------------------------------------------------
module tb_receiver_hs;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned CNT_W       = 4;

    logic             clk_r = 1'b0;
    logic             reset_r;
    logic             req_in;
    logic [7:0]       datain;
    logic             ack_out;
    logic [7:0]       dataout;
    logic             valid;
    logic             rd_en;
    logic             busy;
    logic [CNT_W-1:0] rx_count;
`ifdef RECEIVER_HS_PARITY_EN
    logic             parity_in;
    logic             parity_err;
`endif

    int errors = 0;
    int checks = 0;

    receiver_hs #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_r     (clk_r),
        .reset_r   (reset_r),
        .req_in    (req_in),
        .datain    (datain),
        .ack_out   (ack_out),
        .dataout   (dataout),
        .valid     (valid),
        .rd_en     (rd_en),
        .busy      (busy),
`ifdef RECEIVER_HS_PARITY_EN
        .parity_in (parity_in),
        .parity_err(parity_err),
`endif
        .rx_count  (rx_count)
    );

    always #5 clk_r = ~clk_r;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk_r);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for ack_out to reach lvl; timeout shows as a failed check.
    task automatic wait_ack(input logic lvl, input string tag);
        int n = 0;
        while (ack_out !== lvl && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, ack_out}, {31'd0, lvl});
    endtask

    task automatic xfer(input logic [7:0] b, input string tag);
        req_in = 1'b1;
        datain = b;
        wait_ack(1'b1, {tag, "_ack_hi"});
        chk({tag, "_data"}, {24'd0, dataout}, {24'd0, b});
        req_in = 1'b0;
        wait_ack(1'b0, {tag, "_ack_lo"});
    endtask

    initial begin
        reset_r = 1'b1;
        req_in  = 1'b0;
        datain  = 8'h00;
        rd_en   = 1'b0;
`ifdef RECEIVER_HS_PARITY_EN
        parity_in = 1'b0;
`endif
        tick();
        tick();

        // ---- reset state
        chk("rst_ack", {31'd0, ack_out}, 32'd0);
        chk("rst_data", {24'd0, dataout}, 32'h00);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cnt", {28'd0, rx_count}, 32'd0);
`ifdef RECEIVER_HS_PARITY_EN
        chk("rst_perr", {31'd0, parity_err}, 32'd0);
`endif
        reset_r = 1'b0;

        // ---- single transfer, exact latency: ack on 3rd edge after req
        req_in = 1'b1;
        datain = 8'hA5;
        tick();  // edge t
        chk("lat_e1_ack", {31'd0, ack_out}, 32'd0);
        tick();  // edge t+1
        chk("lat_e2_ack", {31'd0, ack_out}, 32'd0);
        chk("lat_e2_valid", {31'd0, valid}, 32'd0);
        tick();  // edge t+2: capture
        chk("lat_e3_ack", {31'd0, ack_out}, 32'd1);
        chk("lat_e3_data", {24'd0, dataout}, 32'hA5);
        chk("lat_e3_valid", {31'd0, valid}, 32'd1);
        chk("lat_e3_cnt", {28'd0, rx_count}, 32'd1);
        chk("lat_e3_busy", {31'd0, busy}, 32'd1);
        tick();  // ACK -> WAIT_LOW
        chk("ack_state_ack", {31'd0, ack_out}, 32'd1);
        req_in = 1'b0;
        tick();
        tick();
        chk("fall_e2_ack", {31'd0, ack_out}, 32'd1);
        tick();
        chk("fall_e3_ack", {31'd0, ack_out}, 32'd0);
        chk("fall_e3_busy", {31'd0, busy}, 32'd0);
        chk("fall_valid_kept", {31'd0, valid}, 32'd1);
        rd_en = 1'b1;
        tick();
        chk("read_clears_valid", {31'd0, valid}, 32'd0);
        rd_en = 1'b0;
        tick();
        chk("rd_idle_ignored", {31'd0, valid}, 32'd0);

        // ---- back-to-back with rd_en tied high
        reset_r = 1'b1;
        tick();
        reset_r = 1'b0;
        rd_en = 1'b1;
        xfer(8'h01, "b2b1");
        xfer(8'h02, "b2b2");
        xfer(8'h03, "b2b3");
        chk("b2b_cnt", {28'd0, rx_count}, 32'd3);
        rd_en = 1'b0;
        tick();

        // ---- backpressure
        xfer(8'h11, "bp1");
        chk("bp1_valid", {31'd0, valid}, 32'd1);
        req_in = 1'b1;
        datain = 8'h22;
        repeat (6) tick();
        chk("bp_stall_ack", {31'd0, ack_out}, 32'd0);
        chk("bp_stall_data", {24'd0, dataout}, 32'h11);
        chk("bp_stall_busy", {31'd0, busy}, 32'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("bp_cap_ack", {31'd0, ack_out}, 32'd1);
        chk("bp_cap_data", {24'd0, dataout}, 32'h22);
        chk("bp_cap_valid", {31'd0, valid}, 32'd1);
        chk("bp_cnt", {28'd0, rx_count}, 32'd5);
        req_in = 1'b0;
        wait_ack(1'b0, "bp_ack_lo");

        // ---- reset in WAIT_LOW while req held
        rd_en  = 1'b1;
        req_in = 1'b1;
        datain = 8'h5A;
        wait_ack(1'b1, "mid_ack_hi");
        tick();
        tick();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        reset_r = 1'b1;
        rd_en   = 1'b0;
        tick();
        chk("mid_rst_ack", {31'd0, ack_out}, 32'd0);
        chk("mid_rst_valid", {31'd0, valid}, 32'd0);
        chk("mid_rst_cnt", {28'd0, rx_count}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        reset_r = 1'b0;
        tick();
        tick();
        chk("recap_e2_ack", {31'd0, ack_out}, 32'd0);
        tick();
        chk("recap_ack", {31'd0, ack_out}, 32'd1);
        chk("recap_data", {24'd0, dataout}, 32'h5A);
        chk("recap_cnt", {28'd0, rx_count}, 32'd1);
        req_in = 1'b0;
        wait_ack(1'b0, "recap_ack_lo");

        // ---- counter wrap (4-bit): 1 + 14 = 15, then one more -> 0
        rd_en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            xfer(8'(8'h40 + i), "wrap_fill");
        end
        chk("wrap_full", {28'd0, rx_count}, 32'hF);
        xfer(8'hEE, "wrap_last");
        chk("wrap_zero", {28'd0, rx_count}, 32'd0);

`ifdef RECEIVER_HS_PARITY_EN
        // ---- parity: ^8'h03 = 0
        parity_in = 1'b1;
        xfer(8'h03, "par1");
        chk("par_err1", {31'd0, parity_err}, 32'd1);
        parity_in = 1'b0;
        xfer(8'h03, "par0");
        chk("par_err0", {31'd0, parity_err}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/receiver_hs.md
Name: receiver_hs

Overview:
- Receive-side endpoint of the 4-phase req/ack bundled-data CDC transfer.
- Synchronizes the incoming request into clk_r and captures the 8-bit bundled data bus.
- Returns the acknowledge and presents each captured byte to a local consumer over a valid/rd_en handshake, with backpressure.
- Sits in the receiving clock domain, opposite the sender's request/data outputs.

Parameters:
- SYNC_STAGES, 2, flops in the req_in synchronizer chain (legal range 2..4).
- CNT_W, 16, width of the received-word counter.

Ports:
- clk_r  input  1  receive-domain clock.
- reset_r  input  1  reset, synchronous, active-high.
- req_in  input  1  asynchronous request from sender; data valid while high.
- datain  input  8  bundled data from sender; stable while req_in high.
- ack_out  output  1  acknowledge to sender, registered.
- dataout  output  8  captured byte to consumer, registered.
- valid  output  1  dataout holds an unread byte.
- rd_en  input  1  consumer accepts dataout when valid high.
- busy  output  1  high in any state other than IDLE.
- rx_count  output  CNT_W  bytes captured since reset.

Behaviour:
- Clocking and reset
  - One clock, clk_r; reset_r is synchronous and active-high.
  - Reset values: ack_out=0, dataout=8'h00, valid=0, busy=0, rx_count=0, synchronizer flops=0, state=IDLE.
- Synchronizer
  - req_in passes through SYNC_STAGES flops; req_sync is the last stage.
  - datain is NOT synchronized; it is sampled only when req_sync=1, and bundled-data rules guarantee it is stable then.
- FSM states: IDLE, ACK, WAIT_LOW.
  - IDLE: if req_sync=1 and (valid=0 or rd_en=1), then at the edge: dataout<=datain, valid<=1, ack_out<=1, rx_count<=rx_count+1, go to ACK.
  - IDLE: if req_sync=1 and valid=1 and rd_en=0, stay in IDLE with ack_out=0. This backpressure stalls the sender and no data is lost.
  - ACK: unconditional transition to WAIT_LOW; ack_out stays 1.
  - WAIT_LOW: when req_sync=0, ack_out<=0 and go to IDLE. Otherwise hold with ack_out=1.
- Latency
  - req_in high at edge t (meeting setup) gives ack_out high after edge t+SYNC_STAGES, i.e. on the SYNC_STAGES+1th edge counted from t.
  - dataout/valid update on the same edge as ack_out rises.
- Consumer handshake
  - valid=1 and rd_en=1 at an edge clears valid, unless a capture occurs on the same edge; then valid stays 1 and dataout takes the new byte.
  - rd_en while valid=0 is ignored.
- busy = (state != IDLE), registered with the state.
- rx_count wraps from all-ones to 0 with no flag.
- Rules
  - A new capture requires a full ack_out falling edge since the previous capture (4-phase rule); at most one capture per req pulse.
  - A req_in glitch shorter than one clk_r period may be missed. This is legal: the sender holds req until ack.
  - reset_r asserted mid-transfer forces IDLE with ack_out=0. A sender still holding req then sees a fresh request, which is captured after reset releases.

Optional Feature:
- Macro: RECEIVER_HS_PARITY_EN.
- With the macro defined:
  - Extra input parity_in (1) and extra output parity_err (1, reset 0).
  - On each capture, parity_err <= (^datain) ^ parity_in (even parity; 1 means error).
  - parity_err holds until the next capture or reset.
  - The byte is still delivered.
- Without the macro: neither port exists and there is no parity logic.

Test Plan:
- Reset, then req_in=1 with datain=8'hA5 (SYNC_STAGES=2) -> ack_out=1 and dataout=8'hA5, valid=1, rx_count=1 on the 3rd edge; req_in=0 -> ack_out=0 two to three edges later, busy=0.
- Back-to-back transfers 8'h01, 8'h02, 8'h03 with rd_en tied 1 -> three captures in order, rx_count=3, each ack rising only after the previous ack fell.
- Byte 8'h11 captured with rd_en=0, then a second req arrives with 8'h22 -> ack_out stays 0 and dataout stays 8'h11; pulse rd_en -> 8'h22 captured on that same edge with valid kept 1.
- reset_r pulsed in WAIT_LOW with req_in still 1 -> next edge ack_out=0, valid=0, rx_count=0; after release, re-capture of the held data completes.
- Preload rx_count to 16'hFFFF via 65535 transfers, then one more -> rx_count=0.
- RECEIVER_HS_PARITY_EN: datain=8'h03, parity_in=1 -> parity_err=1; datain=8'h03, parity_in=0 -> parity_err=0.
